data_cache: RTL
===============

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 8 blocks x 4 bytes, direct-mapped, write-back, write-allocate.
REQ-002 SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-003 clock  in  1  system clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 read  in  1  CPU byte read request.
REQ-006 write  in  1  CPU byte write request.
REQ-007 address  in  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
REQ-008 writedata  in  8  CPU write byte.
REQ-009 readdata  out  8  CPU read byte.
REQ-010 busywait  out  1  CPU stall request.
REQ-011 mem_read  out  1  memory block read request.
REQ-012 mem_write  out  1  memory block write request.
REQ-013 mem_address  out  6  memory block address {tag,index}.
REQ-014 mem_writedata  out  32  evicted block, byte0 in [7:0] through byte3 in [31:24].
REQ-015 mem_readdata  in  32  fetched block, same byte order as mem_writedata.
REQ-016 mem_busywait  in  1  memory busy; high from request until transfer completes.

Function
REQ-017 Per block, SHALL store: valid bit, dirty bit, 3-bit tag, 32-bit data.
REQ-018 hit SHALL equal valid[index] AND (tag[index]==address[7:5]), evaluated combinationally.
REQ-019 SHALL have FSM states IDLE, WRITE_BACK, MEM_READ, UPDATE.
REQ-020 In IDLE, busywait SHALL be (read|write) AND NOT hit, combinational, so a hit never stalls.
REQ-021 In all states other than IDLE, busywait SHALL be 1.
REQ-022 readdata SHALL be the selected byte of data[index] at offset, combinational; it is valid in the same cycle as a read hit.
REQ-023 On a write hit in IDLE, at the next posedge the cache SHALL write writedata to the byte at offset and set dirty[index]=1.
REQ-024 On an IDLE miss with the indexed block not valid or not dirty, the FSM SHALL go to MEM_READ.
REQ-025 On an IDLE miss with the indexed block valid and dirty, the FSM SHALL go to WRITE_BACK.
REQ-026 In WRITE_BACK: mem_write=1, mem_address={tag[index],index}, mem_writedata=data[index].
REQ-027 WRITE_BACK SHALL exit to MEM_READ on the first posedge where mem_busywait==0.
REQ-028 In MEM_READ: mem_read=1, mem_address={address[7:5],index}.
REQ-029 MEM_READ SHALL exit to UPDATE on the first posedge where mem_busywait==0.
REQ-030 UPDATE SHALL last one cycle with mem_read=mem_write=0.
REQ-031 At the posedge ending UPDATE: data[index]=mem_readdata, tag[index]=address[7:5], valid=1, dirty=0; then go to IDLE.
REQ-032 After UPDATE the access SHALL resolve as a hit in IDLE; a write is then merged per REQ-023.
REQ-033 mem_read and mem_write SHALL never be asserted together; both SHALL be 0 in IDLE and UPDATE.
REQ-034 read and write asserted together SHALL be treated as a write.
REQ-035 CPU inputs SHALL be held stable by the CPU while busywait=1; the cache need not latch them.
REQ-036 A request deasserted in IDLE SHALL cause no state change.

Reset
REQ-037 reset low SHALL immediately force: state=IDLE; all valid and dirty bits=0; all tags and data=0; mem_read=mem_write=0; busywait=0.
REQ-038 Reset mid-WRITE_BACK or mid-MEM_READ SHALL abandon the transfer, with no block updated.
REQ-039 readdata SHALL be 0 after reset.

Structure
REQ-040 Package cache_pkg SHALL hold the state enum and the constants TAG_W=3, INDEX_W=3, OFFSET_W=2, BLOCK_W=32, NUM_BLOCKS=8.
REQ-041 The design SHALL be a single module with no sub-module; tag compare, FSM and arrays all live in data_cache.

Verification (bench uses the 6-bit-address, 32-bit-block memory model with busywait)
REQ-042 Cold read, stimulus: after reset, read addr 0x04 with memory block 1 = 0xDDCCBBAA.
  Required response: MEM_READ at mem_address 1, then UPDATE, then readdata=0xAA, busywait low, no mem_write.
REQ-043 Read hit, stimulus: read addr 0x07 after REQ-042.
  Required response: readdata=0xDD in the same cycle, busywait stays 0, no memory request.
REQ-044 Write hit, stimulus: write 0x5A to addr 0x05.
  Required response: busywait 0, dirty[1]=1, a subsequent read of 0x05 returns 0x5A.
REQ-045 Dirty eviction, stimulus: read addr 0x24 (tag 1, index 1).
  Required response: WRITE_BACK with mem_address 1 and mem_writedata 0xDDCC5AAA, then MEM_READ with mem_address 9, then hit.
REQ-046 Reset in MEM_READ, stimulus: drop reset during MEM_READ.
  Required response: mem_read=0 and busywait=0 immediately, all blocks invalid, a re-read of the same address misses.
REQ-047 Write miss to clean block, stimulus: write 0x11 to addr 0xE0.
  Required response: MEM_READ only (no WRITE_BACK), then byte0=0x11 merged and dirty=1.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry, FSM state encoding and byte-lane helpers for the
// direct-mapped write-back data cache.
package cache_pkg;

    localparam int TAG_W      = 3;
    localparam int INDEX_W    = 3;
    localparam int OFFSET_W   = 2;
    localparam int BLOCK_W    = 32;
    localparam int NUM_BLOCKS = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        MEM_READ   = 2'd2,
        UPDATE     = 2'd3
    } cache_state_t;

    // Byte 0 lives in bits [7:0], byte 3 in bits [31:24].
    function automatic logic [7:0] select_byte(input logic [BLOCK_W-1:0]  blk,
                                               input logic [OFFSET_W-1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = blk[7:0];
            2'd1:    b = blk[15:8];
            2'd2:    b = blk[23:16];
            2'd3:    b = blk[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [BLOCK_W-1:0] merge_byte(input logic [BLOCK_W-1:0]  blk,
                                                      input logic [OFFSET_W-1:0] off,
                                                      input logic [7:0]          b);
        logic [BLOCK_W-1:0] r;
        r = blk;
        case (off)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r = blk;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_cache.sv
// 8 x 4-byte direct-mapped, write-back, write-allocate data cache with a
// block-wide memory port; hits are served combinationally without a stall.
module data_cache
    import cache_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    cache_state_t state_r;
    cache_state_t next_state_s;

    logic [NUM_BLOCKS-1:0] valid_r;
    logic [NUM_BLOCKS-1:0] dirty_r;
    logic [TAG_W-1:0]      tag_r  [NUM_BLOCKS];
    logic [BLOCK_W-1:0]    data_r [NUM_BLOCKS];

    logic [TAG_W-1:0]    tag_in_s;
    logic [INDEX_W-1:0]  index_s;
    logic [OFFSET_W-1:0] offset_s;
    logic                hit_s;
    logic                access_s;
    logic                busywait_s;
    logic                mem_read_s;
    logic                mem_write_s;
    logic [5:0]          mem_address_s;

    assign tag_in_s = address[7:5];
    assign index_s  = address[4:2];
    assign offset_s = address[1:0];
    assign access_s = read | write;
    assign hit_s    = valid_r[index_s] && (tag_r[index_s] == tag_in_s);

    assign readdata      = select_byte(data_r[index_s], offset_s);
    assign mem_writedata = data_r[index_s];
    assign mem_address   = mem_address_s;
    // Reset gates the stall so a CPU still holding a request sees no wait.
    assign busywait      = reset & busywait_s;
    assign mem_read      = mem_read_s;
    assign mem_write     = mem_write_s;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and memory-port decode.
    always_comb begin
        next_state_s  = state_r;
        busywait_s    = 1'b1;
        mem_read_s    = 1'b0;
        mem_write_s   = 1'b0;
        mem_address_s = {tag_in_s, index_s};
        case (state_r)
            IDLE: begin
                busywait_s = access_s & ~hit_s;
                if (access_s && !hit_s) begin
                    if (valid_r[index_s] && dirty_r[index_s]) begin
                        next_state_s = WRITE_BACK;
                    end else begin
                        next_state_s = MEM_READ;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRITE_BACK: begin
                mem_write_s   = 1'b1;
                mem_address_s = {tag_r[index_s], index_s};
                if (!mem_busywait) begin
                    next_state_s = MEM_READ;
                end else begin
                    next_state_s = WRITE_BACK;
                end
            end
            MEM_READ: begin
                mem_read_s = 1'b1;
                if (!mem_busywait) begin
                    next_state_s = UPDATE;
                end else begin
                    next_state_s = MEM_READ;
                end
            end
            UPDATE: begin
                next_state_s = IDLE;
            end
            default: begin
                busywait_s   = 1'b0;
                next_state_s = IDLE;
            end
        endcase
    end

    // Block storage: write-hit byte merge in IDLE, refill at the end of UPDATE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r <= {NUM_BLOCKS{1'b0}};
            dirty_r <= {NUM_BLOCKS{1'b0}};
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tag_r[i]  <= {TAG_W{1'b0}};
                data_r[i] <= {BLOCK_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (write && hit_s) begin
                        data_r[index_s]  <= merge_byte(data_r[index_s], offset_s, writedata);
                        dirty_r[index_s] <= 1'b1;
                    end
                end
                UPDATE: begin
                    data_r[index_s]  <= mem_readdata;
                    tag_r[index_s]   <= tag_in_s;
                    valid_r[index_s] <= 1'b1;
                    dirty_r[index_s] <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
